// File: rtl/e_mdu.sv
// ============================================================================
// Module   : e_mdu
// Brief    : E-stage multiply/divide unit with HI/LO registers and busy stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_LOAD = 4'd4;
  localparam logic [3:0] DIV_LOAD = 4'd9;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        is_div;
  logic        is_sgn;

  logic        start;
  logic        start_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] prod;

  assign start     = (state == IDLE) && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign start_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign busy      = (state != IDLE);

  // Sign-magnitude division: truncates toward zero, remainder follows the
  // dividend, and 0x80000000 / -1 naturally wraps back to 0x80000000.
  always_comb begin
    neg_a = is_sgn & a_q[31];
    neg_b = is_sgn & b_q[31];
    abs_a = neg_a ? (~a_q + 32'd1) : a_q;
    abs_b = neg_b ? (~b_q + 32'd1) : b_q;
    den   = (b_q == 32'd0) ? 32'd1 : abs_b;
    uq    = abs_a / den;
    ur    = abs_a % den;
    quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem   = neg_a ? (~ur + 32'd1) : ur;
    // Low 64 bits of the product are identical for signed and unsigned once
    // operands are extended accordingly.
    prod  = {{32{neg_a}}, a_q} * {{32{neg_b}}, b_q};
  end

  always_comb begin
    case (md_op)
      OP_MFHI: md_out = HI;
      OP_MFLO: md_out = LO;
      default: md_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= E_rs;
            b_q    <= E_rt;
            is_div <= start_div;
            is_sgn <= (md_op == OP_MULT) || (md_op == OP_DIV);
            cnt    <= start_div ? DIV_LOAD : MUL_LOAD;
            state  <= BUSY;
          end else if (md_op == OP_MTHI) begin
            HI <= E_rs;
          end else if (md_op == OP_MTLO) begin
            LO <= E_rs;
          end
        end
        // Counter reaches 0 on entry to DONE, which is the last busy cycle.
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!is_div) begin
            HI <= prod[63:32];
            LO <= prod[31:0];
          end else if (b_q != 32'd0) begin
            HI <= rem;
            LO <= quo;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// Module   : tb_e_mdu
// Brief    : Directed self-checking bench for e_mdu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;

  e_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .E_rs   (E_rs),
    .E_rt   (E_rt),
    .busy   (busy),
    .md_out (md_out),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an op in the current cycle, then check busy/HI/LO over the latency
  // window; returns positioned in cycle T+N+1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = HI;
    old_lo = LO;
    md_op = op;
    E_rs  = rs;
    E_rt  = rt;
    step();
    md_op = 4'd0;
    E_rs  = $urandom;
    E_rt  = $urandom;
    for (int i = 1; i <= n; i++) begin
      chk("busy_window", 32'(busy), 32'd1);
      chk("hi_hold", HI, old_hi);
      chk("lo_hold", LO, old_lo);
      step();
    end
    chk("busy_after", 32'(busy), 32'd0);
    chk("hi_result", HI, exp_hi);
    chk("lo_result", LO, exp_lo);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    md_op    = 4'd5;
    E_rs     = 32'h1111_1111;
    E_rt     = 32'h2222_2222;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_md_out", md_out, 32'd0);

    md_op = 4'd0;
    E_rs  = 32'd0;
    E_rt  = 32'd0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bubble_busy", 32'(busy), 32'd0);
      chk("bubble_hi", HI, 32'd0);
      chk("bubble_lo", LO, 32'd0);
    end

    run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op(4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5, 32'h0000_0000, 32'h0000_000C);
    run_op(4'd2, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);
    run_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op(4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    md_op = 4'd8;
    E_rs  = 32'h0000_1234;
    step();
    md_op = 4'd0;
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_lo", LO, 32'h0000_1234);
    run_op(4'd4, 32'd7, 32'd0, 10, 32'd2, 32'h0000_1234);

    md_op = 4'd7;
    E_rs  = 32'hCAFE_BABE;
    step();
    chk("mthi_busy", 32'(busy), 32'd0);
    md_op = 4'd5;
    #1;
    chk("mfhi_out", md_out, 32'hCAFE_BABE);
    md_op = 4'd6;
    #1;
    chk("mflo_out", md_out, 32'h0000_1234);
    md_op = 4'd9;
    #1;
    chk("none_out", md_out, 32'd0);

    // mult 3*5, with a div and mthi presented while busy
    md_op = 4'd1;
    E_rs  = 32'd3;
    E_rt  = 32'd5;
    step();
    md_op = 4'd0;
    step();
    md_op = 4'd3;
    E_rs  = 32'd100;
    E_rt  = 32'd3;
    step();
    md_op = 4'd7;
    E_rs  = 32'hDEAD_BEEF;
    step();
    md_op = 4'd5;
    #1;
    chk("mfhi_during_busy", md_out, 32'hCAFE_BABE);
    md_op = 4'd0;
    chk("ign_busy_t4", 32'(busy), 32'd1);
    step();
    chk("ign_busy_t5", 32'(busy), 32'd1);
    chk("ign_hi_t5", HI, 32'hCAFE_BABE);
    step();
    chk("ign_busy_t6", 32'(busy), 32'd0);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd15);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("ign_no_restart", 32'(busy), 32'd0);
    end
    chk("ign_lo_final", LO, 32'd15);

    // Reset asserted mid-divide in cycle T+4
    md_op = 4'd3;
    E_rs  = 32'd100;
    E_rt  = 32'd3;
    step();
    md_op = 4'd0;
    step();
    step();
    step();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    md_op = 4'd6;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    chk("abort_md_out", md_out, 32'd0);
    md_op = 4'd0;
    step();
    step();
    reset = 1'b1;
    run_op(4'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 The block SHALL have these ports, one per line:
- clk  input  1  sole clock, rising-edge active
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- md_op  input  4  decoded E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none
- E_rs  input  32  forwarded rs operand from the E stage
- E_rt  input  32  forwarded rt operand from the E stage
- busy  output  1  multi-cycle operation in progress
- md_out  output  32  mfhi/mflo read data, combinational
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

REQ-002 The block SHALL sit in the E stage and take md_op, E_rs and E_rt from the ID-to-EX pipeline register outputs. An all-zero bubble instruction decodes to md_op = 0.

Function
REQ-003 A start SHALL occur in cycle T when md_op is in 1-4 and busy = 0. Operands SHALL be latched into internal registers at the T edge.
- Later changes to E_rs/E_rt SHALL NOT affect the result.

REQ-004 After a start, busy SHALL be 1 for cycles T+1..T+N, where N = 5 for mult/multu and N = 10 for div/divu.
- HI/LO SHALL update at the edge ending cycle T+N.
- busy SHALL be 0 in cycle T+N+1.

REQ-005 The state machine SHALL have exactly three states:
- IDLE: moves to BUSY on start.
- BUSY: a down-counter loads N-1 and decrements each cycle; at 0 the block moves to DONE.
- DONE: commits HI/LO and returns to IDLE.
- The counter and commit placement SHALL realise the exact latency in REQ-004.

REQ-006 mult SHALL produce the signed 64-bit product of rs and rt; multu SHALL produce the unsigned 64-bit product.
- HI SHALL receive bits 63:32 and LO bits 31:0.

REQ-007 div/divu SHALL write the quotient to LO and the remainder to HI.
- Signed quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
- 0x80000000 div 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.

REQ-008 On division by zero, the operation SHALL still run its full 10 busy cycles, and HI/LO SHALL remain unchanged.

REQ-009 mthi/mtlo with busy = 0 SHALL write E_rs to HI/LO at the next edge with no busy cycles.

REQ-010 md_out SHALL equal HI for mfhi, LO for mflo, and 0 otherwise, combinationally from the current register values.

REQ-011 Any md_op in 1-4 or 7-8 presented while busy = 1 SHALL be ignored: no restart, no HI/LO write. The hazard unit SHALL stall every MD instruction in D while busy = 1, or while E holds a start.

REQ-012 Internal result registers SHALL NOT be visible on HI/LO before the commit edge.
- mfhi/mflo during busy returns the old values; stall is the caller's duty.

REQ-013 Back-to-back starts SHALL be allowed: a start in cycle T+N+1 is accepted.

Reset
REQ-014 While reset = 0, regardless of clk, the block SHALL hold HI = 0, LO = 0, busy = 0 and state = IDLE, with the counter and operand latches cleared.

REQ-015 Reset asserted mid-operation SHALL abort the operation with no HI/LO commit. After release, the first rising edge SHALL behave as in IDLE.

REQ-016 md_out SHALL follow REQ-010 during reset, reading 0.

Verification
REQ-017 mult rs = 0xFFFFFFFF, rt = 0x00000002 -> busy high 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE; the same operands via multu -> HI = 0x00000001, LO = 0xFFFFFFFE.

REQ-018 div rs = 0xFFFFFFF9 (-7), rt = 2 -> busy high 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; divu rs = 7, rt = 0 after mtlo 0x1234 -> LO = 0x1234 unchanged after 10 busy cycles.

REQ-019 mult started, then md_op = 3 with new operands in cycle T+2 -> ignored; HI/LO hold the mult result only; busy falls after T+5.

REQ-020 mthi 0xCAFEBABE, then mfhi next cycle -> md_out = 0xCAFEBABE with busy never asserted.

REQ-021 div started, reset pulled low in cycle T+4 -> busy = 0 and HI = LO = 0 immediately without a clock edge; after release, a mult 3 x 4 -> LO = 12 after 5 busy cycles.

REQ-022 Zero-instruction bubble held for 20 cycles after reset -> busy = 0 and HI = LO = 0 throughout.
